// File: rtl/posit_defines.sv
// rtl/posit_defines.sv - shared posit widths, field types and special-value constants
package posit_defines;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    EXTENDED = 2'd1
  } pd_type;

  // Scale must hold one step beyond +/-(N-2)*2^ES so saturation is detectable.
  function automatic int get_scale_width(input int n, input int es, input pd_type t);
    int w;
    w = $clog2(n) + es + 1;
    if (t != NORMAL) w = w + 1;
    return w;
  endfunction

  function automatic int get_fraction_width(input int n, input int es, input pd_type t);
    int w;
    w = n - 3 - es;
    if (w < 1) w = 1;
    if (t != NORMAL) w = n - 1;
    return w;
  endfunction

  function automatic logic [63:0] posit_maxpos(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] posit_minpos(input int n);
    return (n > 1) ? 64'd1 : 64'd0;
  endfunction

  function automatic logic [63:0] posit_nar(input int n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/pd.sv
// rtl/pd.sv - decoded posit bundle: scale, hidden-bit-free fraction and flags
interface pd #(
  parameter int SW = 4,
  parameter int FW = 5
);
  logic signed [SW-1:0] scale;
  logic        [FW-1:0] fraction;
  logic                 nar;
  logic                 sign;
  logic                 zero;
  logic                 guard;
  logic                 round;
  logic                 sticky;

  modport master (output scale, fraction, nar, sign, zero, guard, round, sticky);
  modport slave  (input  scale, fraction, nar, sign, zero, guard, round, sticky);
endinterface

// File: rtl/posit_round_rne.sv
// rtl/posit_round_rne.sv - round-to-nearest-even increment on a posit magnitude
module posit_round_rne #(
  parameter int W = 7
) (
  input  logic [W-1:0] mag_i,
  input  logic         guard_i,
  input  logic         sticky_i,
  output logic [W-1:0] mag_o,
  output logic         overflow_o
);
  logic inc;

  assign inc                 = guard_i & (mag_i[0] | sticky_i);
  assign {overflow_o, mag_o} = {1'b0, mag_i} + {{W{1'b0}}, inc};
endmodule

// File: rtl/posit_encoder.sv
// rtl/posit_encoder.sv - three-stage posit encoder from decoded scale/fraction form
module posit_encoder
  import posit_defines::*;
#(
  parameter int POSIT_WIDTH = 8,
  parameter int POSIT_ES    = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pd.slave                       operand,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [POSIT_WIDTH-1:0] out_posit,
  output logic                   out_valid,
  input  logic                   out_ready
);
  localparam int N   = POSIT_WIDTH;
  localparam int ES  = POSIT_ES;
  localparam int SW  = get_scale_width(N, ES, NORMAL);
  localparam int FW  = get_fraction_width(N, ES, NORMAL);
  localparam int ESW = (ES > 0) ? ES : 1;
  localparam int TW  = 1 + ESW + FW + 3;
  localparam int VW  = N + TW;
  localparam int SHW = $clog2(N) + 1;

  localparam logic signed [SW-1:0] MAX_SCALE = SW'((N - 2) << ES);
  localparam logic signed [SW-1:0] MIN_SCALE = -MAX_SCALE;
  localparam logic [N-1:0]         MAXPOS    = N'(posit_maxpos(N));
  localparam logic [N-1:0]         MINPOS    = N'(posit_minpos(N));
  localparam logic [N-1:0]         NAR       = N'(posit_nar(N));

  logic                 advance;
  logic                 v1_q, v2_q, out_valid_q;
  logic [N-1:0]         out_posit_q;

  logic signed [SW-1:0] k_s;
  logic signed [SW:0]   run_s;
  logic                 fill_d, smax_d, smin_d;
  logic [SHW-1:0]       sh_d;
  logic [ESW-1:0]       e_d;

  logic [SHW-1:0]       sh1_q;
  logic                 fill1_q;
  logic [ESW-1:0]       e1_q;
  logic [FW-1:0]        frac1_q;
  logic [2:0]           grs1_q;
  logic                 sign1_q, nar1_q, zero1_q, smax1_q, smin1_q;

  logic [TW-1:0]        tail;
  logic [VW-1:0]        body, shifted;
  logic [N-2:0]         mag_d;
  logic                 guard_d, sticky_d;

  logic [N-2:0]         mag2_q;
  logic                 g2_q, st2_q, sign2_q, nar2_q, zero2_q, smax2_q, smin2_q;

  logic [N-2:0]         rmag, mag_sat;
  logic                 rovf;
  logic [N-1:0]         res_d;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign out_posit = out_posit_q;

  // S1: split scale into regime k and exponent e; precompute the regime shift.
  always_comb begin
    k_s    = operand.scale >>> ES;
    smax_d = operand.scale > MAX_SCALE;
    smin_d = operand.scale < MIN_SCALE;
    fill_d = !k_s[SW-1];
    e_d    = '0;
    if (ES > 0) e_d = operand.scale[ESW-1:0];
    if (smax_d || smin_d) run_s = (SW+1)'(1);
    else if (fill_d)      run_s = {k_s[SW-1], k_s} + (SW+1)'(1);
    else                  run_s = -{k_s[SW-1], k_s};
    sh_d = SHW'(N) - SHW'(run_s);
  end

  // S2: the run of fill bits is shortened to its true length by the left shift.
  generate
    if (ES > 0) begin : g_es
      assign tail = {!fill1_q, e1_q, frac1_q, grs1_q};
    end else begin : g_no_es
      assign tail = {!fill1_q, frac1_q, grs1_q, e1_q};
    end
  endgenerate

  assign body     = {{N{fill1_q}}, tail};
  assign shifted  = body << sh1_q;
  assign mag_d    = shifted[VW-1 -: N-1];
  assign guard_d  = shifted[VW-N];
  assign sticky_d = |shifted[VW-N-1:0];

  // S3: round, saturate, then apply sign and special values.
  posit_round_rne #(.W(N-1)) u_round (
    .mag_i      (mag2_q),
    .guard_i    (g2_q),
    .sticky_i   (st2_q),
    .mag_o      (rmag),
    .overflow_o (rovf)
  );

  always_comb begin
    mag_sat = rmag;
    if (smax2_q || rovf) mag_sat = MAXPOS[N-2:0];
    else if (smin2_q)    mag_sat = MINPOS[N-2:0];
    res_d = sign2_q ? (N'(0) - {1'b0, mag_sat}) : {1'b0, mag_sat};
    if (zero2_q) res_d = '0;
    if (nar2_q)  res_d = NAR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_posit_q <= '0;
    end else if (advance) begin
      v1_q        <= in_valid;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      if (v2_q) out_posit_q <= res_d;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      sh1_q   <= sh_d;
      fill1_q <= fill_d;
      e1_q    <= e_d;
      frac1_q <= operand.fraction;
      grs1_q  <= {operand.guard, operand.round, operand.sticky};
      sign1_q <= operand.sign;
      nar1_q  <= operand.nar;
      zero1_q <= operand.zero;
      smax1_q <= smax_d;
      smin1_q <= smin_d;

      mag2_q  <= mag_d;
      g2_q    <= guard_d;
      st2_q   <= sticky_d;
      sign2_q <= sign1_q;
      nar2_q  <= nar1_q;
      zero2_q <= zero1_q;
      smax2_q <= smax1_q;
      smin2_q <= smin1_q;
    end
  end
endmodule
